// File: rtl/cpu6502_ldst.sv
// 6502 load/store/transfer subset core with cycle-accurate bus timing and page-cross penalties.
// Define CPU6502_RESET_VECTOR_EN to fetch the start address from FFFC/FFFD after reset.
module cpu6502_ldst #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic [7:0]  di,
  output logic [15:0] ab,
  output logic [7:0]  dout,
  output logic        we,
  output logic        sync,
  output logic [7:0]  a_q,
  output logic [7:0]  x_q,
  output logic [7:0]  y_q,
  output logic [1:0]  nz_q
);

  typedef enum logic [3:0] {
    StVecLo, StVecHi, StFetch, StOp1, StZpIdx, StAbsHi, StAbsIdx, StFixup, StMem
  } state_e;
  typedef enum logic [2:0] {MImp, MImm, MZp, MZpX, MZpY, MAbs, MAbsX, MAbsY} mode_e;
  typedef enum logic [1:0] {RegA, RegX, RegY} reg_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ab_d;
  logic [7:0]  ir_q, ir_d, lo_q, lo_d, hi_q, hi_d, dout_d;
  logic [7:0]  a_d, x_d, y_d;
  logic [1:0]  nz_d;
  logic        carry_q, carry_d, we_d, sync_d;

  mode_e       mode;
  reg_e        rsel, wr_sel;
  logic        store, wr_en, go_fetch, go_mem;
  logic [7:0]  reg_val, idx, wr_val;
  logic [8:0]  idx_sum;
  logic [15:0] fetch_addr, mem_addr;
  state_e      mem_st;

  always_comb begin
    mode  = MImp;
    store = 1'b0;
    rsel  = RegA;
    case (ir_q)
      8'hA9: mode = MImm;
      8'hA5: mode = MZp;
      8'hB5: mode = MZpX;
      8'hAD: mode = MAbs;
      8'hBD: mode = MAbsX;
      8'hB9: mode = MAbsY;
      8'hA2: begin mode = MImm;  rsel = RegX; end
      8'hA6: begin mode = MZp;   rsel = RegX; end
      8'hB6: begin mode = MZpY;  rsel = RegX; end
      8'hAE: begin mode = MAbs;  rsel = RegX; end
      8'hBE: begin mode = MAbsY; rsel = RegX; end
      8'hA0: begin mode = MImm;  rsel = RegY; end
      8'hA4: begin mode = MZp;   rsel = RegY; end
      8'hB4: begin mode = MZpX;  rsel = RegY; end
      8'hAC: begin mode = MAbs;  rsel = RegY; end
      8'hBC: begin mode = MAbsX; rsel = RegY; end
      8'h85: begin mode = MZp;   store = 1'b1; end
      8'h95: begin mode = MZpX;  store = 1'b1; end
      8'h8D: begin mode = MAbs;  store = 1'b1; end
      8'h9D: begin mode = MAbsX; store = 1'b1; end
      8'h99: begin mode = MAbsY; store = 1'b1; end
      8'h86: begin mode = MZp;   store = 1'b1; rsel = RegX; end
      8'h96: begin mode = MZpY;  store = 1'b1; rsel = RegX; end
      8'h8E: begin mode = MAbs;  store = 1'b1; rsel = RegX; end
      8'h84: begin mode = MZp;   store = 1'b1; rsel = RegY; end
      8'h94: begin mode = MZpX;  store = 1'b1; rsel = RegY; end
      8'h8C: begin mode = MAbs;  store = 1'b1; rsel = RegY; end
      default: ;
    endcase
  end

  assign reg_val = (rsel == RegX) ? x_q : (rsel == RegY) ? y_q : a_q;
  assign idx     = (mode == MZpY || mode == MAbsY) ? y_q : x_q;
  assign idx_sum = {1'b0, lo_q} + {1'b0, idx};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    carry_d    = carry_q;
    ab_d       = ab;
    dout_d     = dout;
    we_d       = 1'b0;
    sync_d     = 1'b0;
    wr_en      = 1'b0;
    wr_sel     = rsel;
    wr_val     = di;
    go_fetch   = 1'b0;
    go_mem     = 1'b0;
    fetch_addr = pc_q;
    mem_addr   = ab;
    mem_st     = StMem;
    case (state_q)
      StVecLo: begin
        pc_d[7:0] = di;
        ab_d      = 16'hFFFD;
        state_d   = StVecHi;
      end
      StVecHi: begin
        pc_d       = {di, pc_q[7:0]};
        go_fetch   = 1'b1;
        fetch_addr = {di, pc_q[7:0]};
      end
      StFetch: begin
        ir_d    = di;
        pc_d    = pc_q + 16'd1;
        ab_d    = pc_q + 16'd1;
        state_d = StOp1;
      end
      StOp1: begin
        if (mode != MImp) begin
          lo_d = di;
          pc_d = pc_q + 16'd1;
        end
        case (mode)
          MImm: begin
            wr_en      = 1'b1;
            go_fetch   = 1'b1;
            fetch_addr = pc_q + 16'd1;
          end
          MImp: begin
            // Dummy read at PC; PC stays on the next opcode.
            go_fetch = 1'b1;
            case (ir_q)
              8'hAA: begin wr_en = 1'b1; wr_sel = RegX; wr_val = a_q; end
              8'h8A: begin wr_en = 1'b1; wr_sel = RegA; wr_val = x_q; end
              8'hA8: begin wr_en = 1'b1; wr_sel = RegY; wr_val = a_q; end
              8'h98: begin wr_en = 1'b1; wr_sel = RegA; wr_val = y_q; end
              8'hE8: begin wr_en = 1'b1; wr_sel = RegX; wr_val = x_q + 8'd1; end
              8'hC8: begin wr_en = 1'b1; wr_sel = RegY; wr_val = y_q + 8'd1; end
              8'hCA: begin wr_en = 1'b1; wr_sel = RegX; wr_val = x_q - 8'd1; end
              8'h88: begin wr_en = 1'b1; wr_sel = RegY; wr_val = y_q - 8'd1; end
              default: ;
            endcase
          end
          MZp: begin
            go_mem   = 1'b1;
            mem_addr = {8'h00, di};
          end
          MZpX, MZpY: begin
            ab_d    = {8'h00, di};
            state_d = StZpIdx;
          end
          default: begin
            ab_d    = pc_q + 16'd1;
            state_d = StAbsHi;
          end
        endcase
      end
      StZpIdx: begin
        go_mem   = 1'b1;
        mem_addr = {8'h00, idx_sum[7:0]};
      end
      StAbsHi: begin
        hi_d = di;
        pc_d = pc_q + 16'd1;
        if (mode == MAbs) begin
          go_mem   = 1'b1;
          mem_addr = {di, lo_q};
        end else begin
          ab_d    = {di, idx_sum[7:0]};
          carry_d = idx_sum[8];
          state_d = StAbsIdx;
        end
      end
      StAbsIdx: begin
        if (!store && !carry_q) begin
          wr_en    = 1'b1;
          go_fetch = 1'b1;
        end else begin
          go_mem   = 1'b1;
          mem_st   = StFixup;
          mem_addr = {hi_q + {7'd0, carry_q}, idx_sum[7:0]};
        end
      end
      StFixup, StMem: begin
        wr_en    = !store;
        go_fetch = 1'b1;
      end
      default: go_fetch = 1'b1;
    endcase

    if (go_fetch) begin
      state_d = StFetch;
      ab_d    = fetch_addr;
      sync_d  = 1'b1;
    end
    if (go_mem) begin
      state_d = mem_st;
      ab_d    = mem_addr;
      we_d    = store;
      if (store) dout_d = reg_val;
    end

    a_d  = a_q;
    x_d  = x_q;
    y_d  = y_q;
    nz_d = nz_q;
    if (wr_en) begin
      nz_d = {wr_val[7], wr_val == 8'h00};
      case (wr_sel)
        RegX:    x_d = wr_val;
        RegY:    y_d = wr_val;
        default: a_d = wr_val;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef CPU6502_RESET_VECTOR_EN
      state_q <= StVecLo;
      ab      <= 16'hFFFC;
      sync    <= 1'b0;
      pc_q    <= 16'h0000;
`else
      state_q <= StFetch;
      ab      <= RESET_PC;
      sync    <= 1'b1;
      pc_q    <= RESET_PC;
`endif
      ir_q    <= 8'h00;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      carry_q <= 1'b0;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      nz_q    <= 2'b00;
      we      <= 1'b0;
      dout    <= 8'h00;
    end else if (rdy) begin
      state_q <= state_d;
      ab      <= ab_d;
      sync    <= sync_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      nz_q    <= nz_d;
      we      <= we_d;
      dout    <= dout_d;
    end
  end

endmodule

// File: tb/tb_cpu6502_ldst.sv
// Directed self-checking bench for cpu6502_ldst with a flat 64 KiB read memory and a write log.
// Build with CPU6502_RESET_VECTOR_EN defined to also cover the reset-vector start-up.
module tb_cpu6502_ldst;
`ifdef CPU6502_RESET_VECTOR_EN
  localparam logic [15:0] Base  = 16'hE000;
  localparam logic [15:0] RstAb = 16'hFFFC;
  localparam int          Skip  = 2;
`else
  localparam logic [15:0] Base  = 16'h0000;
  localparam logic [15:0] RstAb = 16'h0000;
  localparam int          Skip  = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdy = 1'b1;
  logic        wr_clr = 1'b1;
  logic [7:0]  di, dout, a_q, x_q, y_q;
  logic [15:0] ab;
  logic        we, sync;
  logic [1:0]  nz_q;
  logic [7:0]  rom [0:65535];
  int          wr_cnt;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  int          n_pass = 0;
  int          n_total = 0;

  logic [15:0] t_ab   [0:31];
  logic        t_we   [0:31];
  logic        t_sync [0:31];
  logic [7:0]  t_do   [0:31];
  logic [7:0]  t_a    [0:31];
  logic [7:0]  t_x    [0:31];
  logic [1:0]  t_nz   [0:31];

  cpu6502_ldst #(.RESET_PC(16'h0000)) dut (
    .clk  (clk),
    .reset(reset),
    .rdy  (rdy),
    .di   (di),
    .ab   (ab),
    .dout (dout),
    .we   (we),
    .sync (sync),
    .a_q  (a_q),
    .x_q  (x_q),
    .y_q  (y_q),
    .nz_q (nz_q)
  );

  always #5 clk = ~clk;
  assign di = rom[ab];

  always @(posedge clk) begin
    if (wr_clr) begin
      wr_cnt  <= 0;
      wr_addr <= 16'h0000;
      wr_data <= 8'h00;
    end else if (we && rdy) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= ab;
      wr_data <= dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[16'hFFFC] = Base[7:0];
    rom[16'hFFFD] = Base[15:8];
  endtask

  task automatic load(input int off, input logic [7:0] b);
    rom[16'(Base + off)] = b;
  endtask

  // Leaves the bench at the negedge inside the first opcode-fetch cycle.
  task automatic start();
    reset  = 1'b1;
    rdy    = 1'b1;
    wr_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    wr_clr = 1'b0;
`ifdef CPU6502_RESET_VECTOR_EN
    check("vec_lo_ab", 32'(ab), 32'hFFFC);
    check("vec_lo_sync", 32'(sync), 0);
    @(negedge clk);
    check("vec_hi_ab", 32'(ab), 32'hFFFD);
    @(negedge clk);
    check("vec_fetch_sync", 32'(sync), 1);
`endif
  endtask

  task automatic run(input int n, input int lo_start, input int lo_len);
    start();
    for (int i = 0; i < n; i++) begin
      t_ab[i] = ab;  t_we[i] = we;  t_sync[i] = sync;  t_do[i] = dout;
      t_a[i]  = a_q; t_x[i]  = x_q; t_nz[i]   = nz_q;
      rdy = !(i >= lo_start && i < lo_start + lo_len);
      @(negedge clk);
    end
    rdy = 1'b1;
  endtask

  initial begin
    int cnt;
    logic ok;

    // LDA #80 ; STA 10
    clear_mem();
    load(0, 8'hA9); load(1, 8'h80); load(2, 8'h85); load(3, 8'h10);
    run(8, 99, 0);
    check("rst_ab", 32'(t_ab[0]), 32'(Base));
    check("rst_sync", 32'(t_sync[0]), 1);
    check("rst_we", 32'(t_we[0]), 0);
    check("rst_do", 32'(t_do[0]), 0);
    check("rst_a", 32'(t_a[0]), 0);
    check("rst_x", 32'(t_x[0]), 0);
    check("rst_nz", 32'(t_nz[0]), 0);
    check("sta_sync1", 32'(t_sync[1]), 0);
    check("sta_sync2", 32'(t_sync[2]), 1);
    check("sta_ab4", 32'(t_ab[4]), 32'h0010);
    check("sta_we3", 32'(t_we[3]), 0);
    check("sta_we4", 32'(t_we[4]), 1);
    check("sta_do4", 32'(t_do[4]), 32'h80);
    check("sta_next_ab", 32'(t_ab[5]), 32'(Base + 16'd4));
    check("sta_we5", 32'(t_we[5]), 0);
    check("lda_a", 32'(a_q), 32'h80);
    check("lda_nz", 32'(nz_q), 32'b10);
    check("sta_wr_cnt", 32'(wr_cnt), 1);
    check("sta_wr_addr", 32'(wr_addr), 32'h0010);

    // LDX #F0 ; LDA 1220,X crosses into page 13
    clear_mem();
    load(0, 8'hA2); load(1, 8'hF0); load(2, 8'hBD); load(3, 8'h20); load(4, 8'h12);
    rom[16'h1310] = 8'h5A; rom[16'h1210] = 8'h77;
    run(10, 99, 0);
    check("absx_x_dummy_ab", 32'(t_ab[5]), 32'h1210);
    check("absx_x_fix_ab", 32'(t_ab[6]), 32'h1310);
    check("absx_x_fix_sync", 32'(t_sync[6]), 0);
    check("absx_x_next", 32'(t_ab[7]), 32'(Base + 16'd5));
    check("absx_x_next_sync", 32'(t_sync[7]), 1);
    check("absx_x_a", 32'(a_q), 32'h5A);
    check("absx_x_nz", 32'(nz_q), 0);

    // LDX #01 ; LDA 1220,X no page cross
    clear_mem();
    load(0, 8'hA2); load(1, 8'h01); load(2, 8'hBD); load(3, 8'h20); load(4, 8'h12);
    rom[16'h1221] = 8'h33;
    run(10, 99, 0);
    check("absx_nc_ab", 32'(t_ab[5]), 32'h1221);
    check("absx_nc_next", 32'(t_ab[6]), 32'(Base + 16'd5));
    check("absx_nc_sync", 32'(t_sync[6]), 1);
    check("absx_nc_a", 32'(a_q), 32'h33);

    // LDA #C3 ; LDY #02 ; STA 12FF,Y
    clear_mem();
    load(0, 8'hA9); load(1, 8'hC3); load(2, 8'hA0); load(3, 8'h02);
    load(4, 8'h99); load(5, 8'hFF); load(6, 8'h12);
    run(12, 99, 0);
    check("absy_st_dummy_ab", 32'(t_ab[7]), 32'h1201);
    check("absy_st_dummy_we", 32'(t_we[7]), 0);
    check("absy_st_ab", 32'(t_ab[8]), 32'h1301);
    check("absy_st_do", 32'(t_do[8]), 32'hC3);
    check("absy_st_next", 32'(t_sync[9]), 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) cnt += int'(t_we[i]);
    check("absy_st_we_cycles", 32'(cnt), 1);
    check("absy_st_wr_cnt", 32'(wr_cnt), 1);
    check("absy_st_wr_addr", 32'(wr_addr), 32'h1301);

    // LDX #FF ; LDA 80,X wraps inside zero page
    clear_mem();
    load(0, 8'hA2); load(1, 8'hFF); load(2, 8'hB5); load(3, 8'h80);
    rom[16'h007F] = 8'h9C; rom[16'h017F] = 8'h11;
    run(10, 99, 0);
    check("zpx_dummy_ab", 32'(t_ab[4]), 32'h0080);
    check("zpx_ab", 32'(t_ab[5]), 32'h007F);
    check("zpx_next_sync", 32'(t_sync[6]), 1);
    check("zpx_a", 32'(a_q), 32'h9C);
    check("zpx_nz", 32'(nz_q), 32'b10);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) if (t_ab[i] == 16'h017F) ok = 1'b0;
    check("zpx_no_page1", 32'(ok), 1);

    // LDX #01 DEX LDX #FF INX LDA #85 TAX TAY INY
    clear_mem();
    load(0, 8'hA2); load(1, 8'h01); load(2, 8'hCA); load(3, 8'hA2); load(4, 8'hFF);
    load(5, 8'hE8); load(6, 8'hA9); load(7, 8'h85); load(8, 8'hAA); load(9, 8'hA8);
    load(10, 8'hC8);
    run(20, 99, 0);
    check("dex_x", 32'(t_x[4]), 0);
    check("dex_nz", 32'(t_nz[4]), 32'b01);
    check("ldx_ff_nz", 32'(t_nz[6]), 32'b10);
    check("inx_x", 32'(t_x[8]), 0);
    check("inx_nz", 32'(t_nz[8]), 32'b01);
    check("impl_dummy_ab", 32'(t_ab[11]), 32'(Base + 16'd9));
    check("impl_next_ab", 32'(t_ab[12]), 32'(Base + 16'd9));
    check("tax_x", 32'(x_q), 32'h85);
    check("iny_y", 32'(y_q), 32'h86);
    check("iny_nz", 32'(nz_q), 32'b10);

    // LDA #5E ; STA C000 with rdy low for three cycles of the write
    clear_mem();
    load(0, 8'hA9); load(1, 8'h5E); load(2, 8'h8D); load(3, 8'h00); load(4, 8'hC0);
    run(12, 5, 3);
    cnt = 0;
    ok  = 1'b1;
    for (int i = 0; i < 12; i++) cnt += int'(t_we[i]);
    for (int i = 5; i < 9; i++) if (t_ab[i] != 16'hC000 || t_do[i] != 8'h5E) ok = 1'b0;
    check("rdy_we_cycles", 32'(cnt), 4);
    check("rdy_frozen", 32'(ok), 1);
    check("rdy_next_ab", 32'(t_ab[9]), 32'(Base + 16'd5));
    check("rdy_next_sync", 32'(t_sync[9]), 1);
    check("rdy_wr_cnt", 32'(wr_cnt), 1);
    check("rdy_wr_data", 32'(wr_data), 32'h5E);

    // Same program, reset pulsed during the write cycle
    start();
    repeat (5) @(negedge clk);
    check("pulse_we_before", 32'(we), 1);
    #1 reset = 1'b1;
    #1;
    check("pulse_we_async", 32'(we), 0);
    check("pulse_ab_async", 32'(ab), 32'(RstAb));
    @(negedge clk);
    reset = 1'b0;
    check("pulse_no_write", 32'(wr_cnt), 0);
    check("pulse_restart_ab", 32'(ab), 32'(RstAb));
    repeat (8 + Skip) @(negedge clk);
    check("pulse_rerun_wr_cnt", 32'(wr_cnt), 1);
    check("pulse_rerun_wr_addr", 32'(wr_addr), 32'hC000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
